// File: rtl/serial_comm_pkg.sv
// Shared definitions for the UART-side word serializer and the receive-side byte assembler.
package serial_comm_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
        NEXT    = 3'd5,
        DONE    = 3'd6,
        ABORT   = 3'd7
    } ser_tx_state_t;

endpackage

// File: rtl/word_serial_tx_if.sv
// Bundle between the serializer (master side) and its word source plus uart_tx (slave side).
import serial_comm_pkg::*;

// Word handshake: a word is accepted on a clock edge where send=1 and ready=1; send while
// ready=0 is dropped. Byte handshake: tx_start pulses one cycle to load tx_data, and tx_data
// stays put until uart_tx lowers tx_busy for that byte.
interface word_serial_tx_if #(
    parameter int NUM_BYTES = WORD_BYTES
) ();
    logic                        send;
    logic [BYTE_W*NUM_BYTES-1:0] data_in;
    logic                        tx_busy;
    logic [BYTE_W-1:0]           tx_data;
    logic                        tx_start;
    logic                        ready;
    logic                        done;
    logic                        error;
    ser_tx_state_t               dbg_state;

    modport master (
        input  send, data_in, tx_busy,
        output tx_data, tx_start, ready, done, error, dbg_state
    );

    modport slave (
        output send, data_in, tx_busy,
        input  tx_data, tx_start, ready, done, error, dbg_state
    );
endinterface

// File: rtl/word_serial_tx.sv
// Splits one word into bytes for uart_tx, pacing on tx_busy and retrying bytes whose
// busy flag never rises.
import serial_comm_pkg::*;

module word_serial_tx #(
    parameter int NUM_BYTES    = WORD_BYTES,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int BUSY_TIMEOUT = 16,
    parameter int MAX_RETRY    = 3
) (
    input logic              clk,
    input logic              reset,
    word_serial_tx_if.master bus
);

    localparam int WORD_W  = BYTE_W * NUM_BYTES;
    localparam int TIMER_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int BCNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int RCNT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    ser_tx_state_t     state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [RCNT_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [BYTE_W-1:0] cur_byte;
    logic [WORD_W-1:0] sreg_shifted;

    // The byte on the wire always sits at the send end of the shift register.
    assign cur_byte     = MSB_FIRST ? sreg_q[WORD_W-1 -: BYTE_W] : sreg_q[BYTE_W-1:0];
    assign sreg_shifted = MSB_FIRST ? (sreg_q << BYTE_W) : (sreg_q >> BYTE_W);

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        byte_cnt_d  = byte_cnt_q;
        retry_cnt_d = retry_cnt_q;
        timer_d     = timer_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.send) begin
                    sreg_d      = bus.data_in;
                    byte_cnt_d  = '0;
                    retry_cnt_d = '0;
                    ready_d     = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = cur_byte;
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (timer_q == TIMER_W'(BUSY_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_cnt_q == RCNT_W'(MAX_RETRY)) begin
                        error_d = 1'b1;
                        state_d = ABORT;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = LOAD;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) state_d = NEXT;
            end
            NEXT: begin
                sreg_d      = sreg_shifted;
                retry_cnt_d = '0;
                // Cleared rather than incremented on the last byte so the counter never wraps.
                if (byte_cnt_q == BCNT_W'(NUM_BYTES - 1)) begin
                    byte_cnt_d = '0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = LOAD;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                retry_cnt_d = '0;
                ready_d     = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            byte_cnt_q  <= '0;
            retry_cnt_q <= '0;
            timer_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            byte_cnt_q  <= byte_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_word_serial_tx.sv
// Directed bench for word_serial_tx: one MSB-first and one LSB-first instance, each paced
// by a small uart_tx busy model.
module tb_word_serial_tx;
    import serial_comm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    word_serial_tx_if #(.NUM_BYTES(3)) ifa ();
    word_serial_tx_if #(.NUM_BYTES(3)) ifb ();

    word_serial_tx #(.NUM_BYTES(3), .MSB_FIRST(1'b1), .BUSY_TIMEOUT(16), .MAX_RETRY(3)) u_msb (
        .clk(clk), .reset(reset), .bus(ifa.master)
    );
    word_serial_tx #(.NUM_BYTES(3), .MSB_FIRST(1'b0), .BUSY_TIMEOUT(16), .MAX_RETRY(3)) u_lsb (
        .clk(clk), .reset(reset), .bus(ifb.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // uart_tx busy models: busy rises rise_x cycles after tx_start and stays len_x cycles
    logic mbusy_a = 1'b0, mbusy_b = 1'b0;
    logic force_a = 1'b0;
    bit   model_on_a = 1'b1, model_on_b = 1'b1;
    int   rise_a = 1, len_a = 3, rise_b = 1, len_b = 3;

    assign ifa.tx_busy = mbusy_a | force_a;
    assign ifb.tx_busy = mbusy_b;

    always begin
        @(negedge clk);
        if (ifa.tx_start && model_on_a) begin
            repeat (rise_a) @(posedge clk);
            #1 mbusy_a = 1'b1;
            repeat (len_a) @(posedge clk);
            #1 mbusy_a = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        if (ifb.tx_start && model_on_b) begin
            repeat (rise_b) @(posedge clk);
            #1 mbusy_b = 1'b1;
            repeat (len_b) @(posedge clk);
            #1 mbusy_b = 1'b0;
        end
    end

    // Monitors: byte capture, pulse counts, tx_data stability while a byte is in flight
    logic [7:0] got_a[$], got_b[$];
    logic [7:0] exp_q[$];
    logic [7:0] held_a = 8'h00, held_b = 8'h00;
    int starts_a = 0, dones_a = 0, errs_a = 0, viol_a = 0;
    int starts_b = 0, dones_b = 0, errs_b = 0, viol_b = 0;

    always @(negedge clk) begin
        if (ifa.tx_start) begin
            got_a.push_back(ifa.tx_data);
            starts_a++;
            held_a = ifa.tx_data;
        end
        if (ifa.done)  dones_a++;
        if (ifa.error) errs_a++;
        if ((ifa.dbg_state == WAIT_HI || ifa.dbg_state == WAIT_LO) && ifa.tx_data !== held_a)
            viol_a++;
        if (ifb.tx_start) begin
            got_b.push_back(ifb.tx_data);
            starts_b++;
            held_b = ifb.tx_data;
        end
        if (ifb.done)  dones_b++;
        if (ifb.error) errs_b++;
        if ((ifb.dbg_state == WAIT_HI || ifb.dbg_state == WAIT_LO) && ifb.tx_data !== held_b)
            viol_b++;
    end

    task automatic send_word(input bit sel, input logic [23:0] d);
        @(posedge clk);
        #1;
        if (sel) begin ifb.data_in = d; ifb.send = 1'b1; end
        else     begin ifa.data_in = d; ifa.send = 1'b1; end
        @(posedge clk);
        #1;
        ifa.send = 1'b0;
        ifb.send = 1'b0;
    endtask

    task automatic wait_ready(input bit sel, input int budget, input string name);
        int n = 0;
        logic rdy;
        do begin
            @(negedge clk);
            n++;
            rdy = sel ? ifb.ready : ifa.ready;
        end while (!rdy && n < budget);
        check({name, "_ready"}, {31'd0, rdy}, 32'd1);
    endtask

    task automatic check_bytes(input bit sel, input string name);
        logic [7:0] q[$];
        q = sel ? got_b : got_a;
        check({name, "_nbytes"}, q.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check($sformatf("%s_byte%0d", name, k), (k < q.size()) ? {24'd0, q[k]} : 32'hxxxx_xxxx,
                  {24'd0, e});
        end
    endtask

    typedef struct {
        bit          sel;
        logic [23:0] data;
        int          rise;
        int          len;
        logic [23:0] wire_order;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, e0, n;
        bit seen;

        vecs[0] = '{1'b0, 24'hA1B2C3,  1, 3, 24'hA1B2C3};
        vecs[1] = '{1'b1, 24'h123456,  2, 5, 24'h563412};
        vecs[2] = '{1'b0, 24'h5A0FF0, 10, 1, 24'h5A0FF0};
        vecs[3] = '{1'b1, 24'hA1B2C3,  7, 2, 24'hC3B2A1};
        vecs[4] = '{1'b0, 24'h000001,  4, 2, 24'h000001};
        vecs[5] = '{1'b1, 24'h800000,  3, 4, 24'h000080};

        ifa.send = 1'b0; ifa.data_in = '0;
        ifb.send = 1'b0; ifb.data_in = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready_a",    {31'd0, ifa.ready},    32'd1);
        check("rst_tx_start_a", {31'd0, ifa.tx_start}, 32'd0);
        check("rst_done_a",     {31'd0, ifa.done},     32'd0);
        check("rst_error_a",    {31'd0, ifa.error},    32'd0);
        check("rst_tx_data_a",  {24'd0, ifa.tx_data},  32'd0);
        check("rst_state_a",    {29'd0, ifa.dbg_state}, {29'd0, IDLE});
        check("rst_ready_b",    {31'd0, ifb.ready},    32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Latency: send in IDLE, LOAD next cycle, tx_start in the cycle after
        rise_a = 1; len_a = 2;
        got_a.delete();
        exp_q.push_back(8'hC0); exp_q.push_back(8'hFF); exp_q.push_back(8'hEE);
        @(posedge clk);
        #1 ifa.data_in = 24'hC0FFEE; ifa.send = 1'b1;
        @(posedge clk);
        #1 ifa.send = 1'b0;
        @(negedge clk);
        check("lat_load_start", {31'd0, ifa.tx_start}, 32'd0);
        check("lat_load_ready", {31'd0, ifa.ready},    32'd0);
        @(negedge clk);
        check("lat_start_pulse", {31'd0, ifa.tx_start}, 32'd1);
        check("lat_start_data",  {24'd0, ifa.tx_data},  32'h0000_00C0);
        wait_ready(1'b0, 300, "lat");
        check_bytes(1'b0, "lat");

        // Table-driven words on both byte orders
        foreach (vecs[i]) begin
            if (vecs[i].sel) begin
                rise_b = vecs[i].rise; len_b = vecs[i].len; got_b.delete();
                s0 = dones_b; e0 = errs_b;
            end else begin
                rise_a = vecs[i].rise; len_a = vecs[i].len; got_a.delete();
                s0 = dones_a; e0 = errs_a;
            end
            exp_q.push_back(vecs[i].wire_order[23:16]);
            exp_q.push_back(vecs[i].wire_order[15:8]);
            exp_q.push_back(vecs[i].wire_order[7:0]);
            send_word(vecs[i].sel, vecs[i].data);
            wait_ready(vecs[i].sel, 400, $sformatf("vec%0d", i));
            check_bytes(vecs[i].sel, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_done", i),
                  (vecs[i].sel ? dones_b : dones_a) - s0, 32'd1);
            check($sformatf("vec%0d_err", i),
                  (vecs[i].sel ? errs_b : errs_a) - e0, 32'd0);
        end

        // busy never rises: 1 try + 3 retries of byte 0, then abort
        model_on_a = 1'b0;
        got_a.delete();
        s0 = starts_a; d0 = dones_a; e0 = errs_a;
        send_word(1'b0, 24'hA1B2C3);
        wait_ready(1'b0, 200, "timeout");
        check("timeout_starts", starts_a - s0, 32'd4);
        check("timeout_err",    errs_a - e0,   32'd1);
        check("timeout_done",   dones_a - d0,  32'd0);
        check("timeout_state",  {29'd0, ifa.dbg_state}, {29'd0, IDLE});
        n = 0;
        foreach (got_a[k]) if (got_a[k] == 8'hA1) n++;
        check("timeout_byte0_only", n, 32'd4);
        model_on_a = 1'b1;

        // uart busy from elsewhere at send: hold in LOAD until it drops
        rise_a = 1; len_a = 2;
        force_a = 1'b1;
        got_a.delete();
        s0 = starts_a; d0 = dones_a;
        exp_q.push_back(8'h3C); exp_q.push_back(8'h5A); exp_q.push_back(8'h7E);
        send_word(1'b0, 24'h3C5A7E);
        repeat (20) @(negedge clk);
        check("busy_hold_starts", starts_a - s0, 32'd0);
        check("busy_hold_state",  {29'd0, ifa.dbg_state}, {29'd0, LOAD});
        @(posedge clk);
        #1 force_a = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            if (ifa.tx_start) seen = 1'b1;
        end
        check("busy_release_start", {31'd0, seen}, 32'd1);
        check("busy_release_data",  {24'd0, ifa.tx_data}, 32'h0000_003C);
        wait_ready(1'b0, 300, "busy_release");
        check_bytes(1'b0, "busy_release");
        check("busy_release_done", dones_a - d0, 32'd1);

        // Reset during WAIT_LO of the third byte
        rise_a = 1; len_a = 8;
        s0 = starts_a; d0 = dones_a; e0 = errs_a;
        send_word(1'b0, 24'h0A0B0C);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (starts_a - s0 == 3 && ifa.dbg_state == WAIT_LO) seen = 1'b1;
        end
        check("rst_mid_reached", {31'd0, seen}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ready",    {31'd0, ifa.ready},    32'd1);
        check("rst_mid_tx_start", {31'd0, ifa.tx_start}, 32'd0);
        check("rst_mid_done",     {31'd0, ifa.done},     32'd0);
        check("rst_mid_state",    {29'd0, ifa.dbg_state}, {29'd0, IDLE});
        for (int k = 0; k < 20 && mbusy_a; k++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", dones_a - d0, 32'd0);
        check("rst_mid_no_err",  errs_a - e0,  32'd0);
        rise_a = 2; len_a = 3;
        got_a.delete();
        d0 = dones_a;
        exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        send_word(1'b0, 24'hFFFFFF);
        wait_ready(1'b0, 300, "after_rst");
        check_bytes(1'b0, "after_rst");
        check("after_rst_done", dones_a - d0, 32'd1);

        // send held high through a whole transfer, including the DONE cycle
        rise_a = 2; len_a = 3;
        got_a.delete();
        s0 = starts_a; d0 = dones_a;
        exp_q.push_back(8'h0F); exp_q.push_back(8'h1E); exp_q.push_back(8'h2D);
        @(posedge clk);
        #1 ifa.data_in = 24'h0F1E2D; ifa.send = 1'b1;
        @(posedge clk);
        #1 ifa.data_in = 24'h555555;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (ifa.done) seen = 1'b1;
        end
        check("spam_done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1 ifa.send = 1'b0;
        repeat (10) @(negedge clk);
        check("spam_starts", starts_a - s0, 32'd3);
        check("spam_dones",  dones_a - d0,  32'd1);
        check("spam_ready",  {31'd0, ifa.ready}, 32'd1);
        check_bytes(1'b0, "spam");

        check("tx_data_stable", viol_a + viol_b, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
